// File: rtl/bus_master_seq.sv
// Sequencing bus initiator: writes an incrementing pattern block, then (with
// BUS_MASTER_VERIFY_EN defined) reads it back and compares every word.
//
// state     | meaning
// IDLE      | waiting for start, outputs parked
// REQ       | bus requested, waiting for first grant
// WRITE     | one pattern word per granted cycle
// RD_ADDR   | read address issued
// RD_WAIT   | holding address for the slave read latency
// CHECK     | m_din compared against the expected pattern word
// FIN       | one-cycle done pulse, bus released
module bus_master_seq #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [7:0]  length,
    input  logic [31:0] seed,
    input  logic        m_grant,
    input  logic [63:0] m_din,
    output logic        m_req,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [31:0] m_dout,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_CHECK,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] seed_q, seed_d;
    logic [7:0]  idx_q, idx_d;
    logic        m_req_q, m_req_d;
    logic        m_wr_q, m_wr_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [31:0] m_dout_q, m_dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  idx_nxt;
    logic        last_word;
    logic        to_fin;
    logic [16:0] end_addr;
    logic        range_bad;

    assign idx_nxt   = idx_q + 8'd1;
    assign last_word = (idx_q == len_q - 8'd1);
    // Last address computed one bit wider so a block running past 0xFFFF is still caught.
    assign end_addr  = {1'b0, base_addr} + {9'd0, length} - 17'd1;
    assign range_bad = (base_addr < 16'h0100) || (end_addr > 17'h001FF);

`ifdef BUS_MASTER_VERIFY_EN
    logic [3:0]  wait_q, wait_d;
    logic        restart_q, restart_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        mismatch;

    assign mismatch = (m_din !== {32'd0, seed_q + {24'd0, idx_q}});
`else
    logic unused_din;
    assign unused_din = (^m_din) ^ (RD_LAT > 1);
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        seed_d   = seed_q;
        idx_d    = idx_q;
        m_req_d  = m_req_q;
        m_wr_d   = m_wr_q;
        m_addr_d = m_addr_q;
        m_dout_d = m_dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        to_fin   = 1'b0;
`ifdef BUS_MASTER_VERIFY_EN
        wait_d    = wait_q;
        restart_d = restart_q;
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    seed_d = seed;
                    idx_d  = 8'd0;
                    err_d  = 1'b0;
`ifdef BUS_MASTER_VERIFY_EN
                    err_cnt_d = 8'd0;
`endif
                    if (length == 8'd0) begin
                        to_fin = 1'b1;
                    end else if (range_bad) begin
                        err_d  = 1'b1;
                        to_fin = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        m_req_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    state_d  = S_WRITE;
                    m_wr_d   = 1'b1;
                    m_addr_d = base_q;
                    m_dout_d = seed_q;
                end
            end
            S_WRITE: begin
                if (m_grant) begin
                    if (last_word) begin
                        idx_d = 8'd0;
`ifdef BUS_MASTER_VERIFY_EN
                        state_d  = S_RD_ADDR;
                        m_wr_d   = 1'b0;
                        m_addr_d = base_q;
                        m_dout_d = 32'd0;
`else
                        to_fin = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_nxt;
                        m_addr_d = base_q + {8'd0, idx_nxt};
                        m_dout_d = seed_q + {24'd0, idx_nxt};
                    end
                end
            end
`ifdef BUS_MASTER_VERIFY_EN
            S_RD_ADDR: begin
                if (m_grant) begin
                    state_d = S_RD_WAIT;
                    wait_d  = 4'(RD_LAT - 2);
                end
            end
            // A grant gap invalidates the slave pipeline, so the read is reissued.
            S_RD_WAIT: begin
                if (!m_grant) begin
                    restart_d = 1'b1;
                end else if (restart_q) begin
                    restart_d = 1'b0;
                    state_d   = S_RD_ADDR;
                end else if (wait_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (!m_grant) begin
                    restart_d = 1'b1;
                end else if (restart_q) begin
                    restart_d = 1'b0;
                    state_d   = S_RD_ADDR;
                end else begin
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                    if (last_word) begin
                        to_fin = 1'b1;
                    end else begin
                        idx_d    = idx_nxt;
                        state_d  = S_RD_ADDR;
                        m_addr_d = base_q + {8'd0, idx_nxt};
                    end
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (to_fin) begin
            state_d  = S_FIN;
            m_req_d  = 1'b0;
            m_wr_d   = 1'b0;
            m_addr_d = 16'd0;
            m_dout_d = 32'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= 16'd0;
            len_q    <= 8'd0;
            seed_q   <= 32'd0;
            idx_q    <= 8'd0;
            m_req_q  <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= 16'd0;
            m_dout_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef BUS_MASTER_VERIFY_EN
            wait_q    <= 4'd0;
            restart_q <= 1'b0;
            err_cnt_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            seed_q   <= seed_d;
            idx_q    <= idx_d;
            m_req_q  <= m_req_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            m_dout_q <= m_dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef BUS_MASTER_VERIFY_EN
            wait_q    <= wait_d;
            restart_q <= restart_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign m_req  = m_req_q;
    assign m_wr   = m_wr_q;
    assign m_addr = m_addr_q;
    assign m_dout = m_dout_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
`ifdef BUS_MASTER_VERIFY_EN
    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq with a 256x64 slave model (2-cycle read latency).
// Expectations follow the build: BUS_MASTER_VERIFY_EN selects the read-back timings.
module tb_bus_master_seq;

`ifdef BUS_MASTER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Cycle (start cycle = 1) in which done shows for a 4-word block.
    localparam int DONE4    = VERIFY ? 19 : 7;
    localparam int RST_CYC  = VERIFY ? 8 : 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  length;
    logic [31:0] seed;
    logic        m_grant;
    logic [63:0] m_din;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    logic        grant_en = 1'b1;
    logic        corrupt  = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    logic [63:0] mem [256];
    logic [63:0] rd_p1;
    logic [47:0] wr_log [1024];
    int          wr_total = 0;

    bus_master_seq #(.RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .seed(seed), .m_grant(m_grant), .m_din(m_din),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
        .busy(busy), .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign m_grant = m_req & grant_en;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 64'd0;
    end

    always @(posedge clk) begin
        if (m_req && m_grant && m_wr) begin
            mem[m_addr[7:0]] <= {32'd0, m_dout};
            wr_log[wr_total & 1023] <= {m_addr, m_dout};
            wr_total <= wr_total + 1;
        end
        rd_p1 <= (corrupt && m_addr == 16'h0102) ? 64'h0000_0000_DEAD_0000 : mem[m_addr[7:0]];
        m_din <= rd_p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [15:0] b, input logic [7:0] n, input logic [31:0] s,
                       input int drop_at, input int drop_len, input logic [15:0] hold_addr,
                       output int done_c, output int busy_c, output int reqs,
                       output int w0, output int hold_bad);
        @(negedge clk);
        base_addr = b;
        length    = n;
        seed      = s;
        start     = 1'b1;
        w0        = wr_total;
        done_c    = 0;
        busy_c    = 0;
        reqs      = 0;
        hold_bad  = 0;
        for (int c = 2; c <= 200 && done_c == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_req) reqs++;
            if (busy) busy_c++;
            if (done) done_c = c;
            if (c >= drop_at && c < drop_at + drop_len) begin
                grant_en = 1'b0;
                if (m_addr !== hold_addr || m_req !== 1'b1) hold_bad++;
            end else begin
                grant_en = 1'b1;
            end
        end
        grant_en = 1'b1;
    endtask

    task automatic chk_writes(input int w0, input int exp_n, input logic [15:0] b, input logic [31:0] s);
        chk("wr_count", 64'(wr_total - w0), 64'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk("wr_word", {16'd0, wr_log[(w0 + i) & 1023]}, {16'd0, 16'(b + 16'(i)), 32'(s + 32'(i))});
        end
    endtask

    initial begin
        int dc, bc, rq, w0, hb;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 16'd0;
        length    = 8'd0;
        seed      = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_m_req",  64'(m_req),  64'd0);
        chk("rst_m_wr",   64'(m_wr),   64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_dout", 64'(m_dout), 64'd0);
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_err",    64'(err),    64'd0);
        chk("rst_errcnt", 64'(err_count), 64'd0);
        reset = 1'b0;

        // Nominal block
        run(16'h0100, 8'd4, 32'hA5A5_0000, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("a_done_cyc", 64'(dc), 64'(DONE4));
        chk("a_busy_cyc", 64'(bc), 64'(DONE4 - 2));
        chk("a_req_cyc",  64'(rq), 64'(DONE4 - 2));
        chk("a_err",      64'(err), 64'd0);
        chk("a_errcnt",   64'(err_count), 64'd0);
        chk_writes(w0, 4, 16'h0100, 32'hA5A5_0000);
        @(negedge clk);
        chk("a_done_pulse", 64'(done), 64'd0);

        // Top of window with seed wrap
        run(16'h01FC, 8'd4, 32'hFFFF_FFFE, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("b_done_cyc", 64'(dc), 64'(DONE4));
        chk("b_err",      64'(err), 64'd0);
        chk_writes(w0, 4, 16'h01FC, 32'hFFFF_FFFE);

        // Range error past the top
        run(16'h01FE, 8'd4, 32'h0, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("c_done_cyc", 64'(dc), 64'd2);
        chk("c_req_cyc",  64'(rq), 64'd0);
        chk("c_busy_cyc", 64'(bc), 64'd0);
        chk("c_err",      64'(err), 64'd1);
        chk("c_wr_count", 64'(wr_total - w0), 64'd0);
        repeat (3) @(negedge clk);
        chk("c_err_sticky", 64'(err), 64'd1);

        // Range error below the window
        run(16'h00FF, 8'd1, 32'h0, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("d_done_cyc", 64'(dc), 64'd2);
        chk("d_err",      64'(err), 64'd1);
        chk("d_req_cyc",  64'(rq), 64'd0);

        // Zero length clears err and issues nothing
        run(16'h0150, 8'd0, 32'h0, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("e_done_cyc", 64'(dc), 64'd2);
        chk("e_err",      64'(err), 64'd0);
        chk("e_req_cyc",  64'(rq), 64'd0);
        chk("e_wr_count", 64'(wr_total - w0), 64'd0);

`ifdef BUS_MASTER_VERIFY_EN
        // Corrupted word at 0x0102
        corrupt = 1'b1;
        run(16'h0100, 8'd4, 32'hA5A5_0000, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        corrupt = 1'b0;
        chk("g_done_cyc", 64'(dc), 64'd19);
        chk("g_err",      64'(err), 64'd1);
        chk("g_errcnt",   64'(err_count), 64'd1);
`endif

        // Grant withheld for 3 cycles during the second write
        run(16'h0100, 8'd4, 32'h1234_5678, 4, 3, 16'h0101, dc, bc, rq, w0, hb);
        chk("f_done_cyc", 64'(dc), 64'(DONE4 + 3));
        chk("f_hold_bad", 64'(hb), 64'd0);
        chk("f_err",      64'(err), 64'd0);
        chk("f_errcnt",   64'(err_count), 64'd0);
        chk_writes(w0, 4, 16'h0100, 32'h1234_5678);

        // Reset mid-operation, then a clean run
        @(negedge clk);
        base_addr = 16'h0100;
        length    = 8'd4;
        seed      = 32'h1111_0000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RST_CYC - 2) @(negedge clk);
        chk("h_pre_req", 64'(m_req), 64'd1);
        chk("h_pre_wr",  64'(m_wr),  VERIFY ? 64'd0 : 64'd1);
        reset = 1'b1;
        #1;
        chk("h_m_req",  64'(m_req),  64'd0);
        chk("h_m_wr",   64'(m_wr),   64'd0);
        chk("h_m_addr", 64'(m_addr), 64'd0);
        chk("h_busy",   64'(busy),   64'd0);
        chk("h_done",   64'(done),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        run(16'h0100, 8'd4, 32'h1111_0000, 0, 0, 16'h0, dc, bc, rq, w0, hb);
        chk("h_done_cyc", 64'(dc), 64'(DONE4));
        chk("h_err",      64'(err), 64'd0);
        chk_writes(w0, 4, 16'h0100, 32'h1111_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_master_seq.md
# bus_master_seq

Sequencing bus initiator for the single-master system bus. On `start` it requests the bus, writes a block of incrementing 32-bit pattern words to consecutive slave addresses, then reads the block back and checks every word. It drives the bus's master port (`m_req`, `m_wr`, `m_addr`, `m_dout`), consumes `m_grant`/`m_din`, and serves as the built-in traffic generator and self-test for the bus and slave.

## Interface
- `RD_LAT`, 2: cycles from a read address being driven until `m_din` holds that address's data.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: launch request, sampled only in IDLE.
- `base_addr` in 16: first slave address; captured at start.
- `length` in 8: number of words to transfer; captured at start.
- `seed` in 32: pattern for word i is `seed + i` (mod 2^32); captured at start.
- `m_grant` in 1: bus grant.
- `m_din` in 64: read data returned by bus.
- `m_req` out 1: bus request.
- `m_wr` out 1: 1 = write, 0 = read.
- `m_addr` out 16: transfer address.
- `m_dout` out 32: write data.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky until next start; range error or any compare mismatch.
- `err_count` out 8: mismatching words, saturating at 255.

## Operation
- States: IDLE, REQ, WRITE, RD_ADDR, RD_WAIT, CHECK, FIN.
- IDLE: on `start`=1 capture base/length/seed, clear `err`/`err_count`, index i=0, `busy`=1. If `length`=0, go to FIN directly. Otherwise check range (see below), then go to REQ.
- Legal window is 0x0100–0x01FF.
  - If `base_addr` < 0x0100 or `base_addr + length - 1` > 0x01FF (computed 17-bit), set `err` and go to FIN.
  - No bus cycle is issued in that case.
- REQ: `m_req`=1. Go to WRITE when `m_grant`=1.
- WRITE: `m_wr`=1, `m_addr`=base+i, `m_dout`=seed+i. Each granted cycle retires one word, i++.
  - After word length-1, reset i=0 and go to RD_ADDR.
- RD_ADDR: `m_wr`=0, `m_addr`=base+i, `m_dout`=0. Go to RD_WAIT.
- RD_WAIT: hold the address for RD_LAT-1 cycles, then go to CHECK.
- CHECK: compare `m_din[31:0]` to seed+i and `m_din[63:32]` to 0. Any X/Z or mismatch counts as an error.
  - On error: `err`=1 and `err_count`++ (saturating).
  - i++. Go to RD_ADDR, or to FIN after the last word.
- FIN: `m_req`=0, `done`=1 for one cycle, `busy`=0, return to IDLE.
- Grant loss: while `m_grant`=0 in WRITE/RD_ADDR/RD_WAIT/CHECK, the state, index, and outputs freeze and `m_req` stays 1. Progress resumes on the cycle grant returns. A read in progress restarts at RD_ADDR.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `m_req`=0, `m_wr`=0, `m_addr`=0, `m_dout`=0, `busy`=0, `done`=0, `err`=0, `err_count`=0, state IDLE. All outputs are registered.
- Reset mid-operation aborts immediately: `m_req` drops asynchronously and no `done` is issued.
- start to first `m_req`: 1 cycle. Grant to first write on the bus: 1 cycle.
- Writes: one per cycle under continuous grant.
- Reads: 1 + RD_LAT cycles per word.
- Total, N words, constant grant: 1 (IDLE) + 1 (REQ) + N + N·(1+RD_LAT) + 1 (FIN) cycles.
- `done` and `busy` falling coincide in the FIN cycle.

## Configuration
- `BUS_MASTER_VERIFY_EN` defined: full write + read-back + compare as described.
- Not defined:
  - After the last WRITE, go straight to FIN; RD_ADDR/RD_WAIT/CHECK are not built.
  - `err_count` is tied to 0.
  - `err` reports range errors only.
  - Total cycles: N+3.

## Test plan
- Write/read, macro on: base 0x0100, length 4, seed 0xA5A50000, grant=req, `s_dout` from a 256×64 model → writes 0xA5A50000..03 at 0x0100..0x0103, 4 reads, `done` at cycle 3+4+12=19, `err`=0, `err_count`=0.
- Corrupted slave: as above, but the model returns 0xDEAD0000 at 0x0102 → `err`=1, `err_count`=1, `done` still pulses.
- Range error: base 0x01FE, length 4 → no `m_req`, `err`=1, `done` pulse 2 cycles after start.
- Zero length: length 0 → `done` 2 cycles after start, no bus traffic, `err`=0.
- Grant loss: force `m_grant`=0 for 3 cycles during the 2nd write → `m_addr`=0x0101 held, no duplicate or skipped write, completion delayed exactly 3 cycles.
- Reset mid-read: assert `reset` in RD_WAIT → all outputs 0 in the same cycle; next start runs normally.
